seven_seg_display_ctrl: RTL and testbench
=========================================

# seven_seg_display_ctrl

Scan controller for the 4-digit multiplexed seven-segment display. It cycles through the digits one at a time, with a blanking gap between digits to suppress ghosting. For each digit it drives the active-low anode, decodes the matching nibble of a displayed value to active-low cathodes, and accepts new values through a load/ack handshake that applies updates only at frame boundaries, so a frame never shows a torn value. It replaces the free-running divided-clock scanner: the whole block runs on the system clock with internal tick counting.

## Interface
- `TICKS_PER_DIGIT`, 100000 — clock cycles each digit is driven; legal ≥ 2.
- `BLANK_TICKS`, 1000 — clock cycles all anodes are off between digits; legal ≥ 1.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, no other clock domains.
- `enable`  in  1  high: drive the display; low: force the display dark while sequencing continues.
- `value`  in  16  hex value to show; `value[3:0]` is the rightmost digit (`anode[0]`).
- `dp`  in  4  decimal point per digit, active-high, sampled live (not shadowed).
- `load`  in  1  one-cycle request to latch `value` for display.
- `ack`  out  1  one-cycle pulse: a requested value is now being displayed.
- `anode`  out  4  active-low digit select; at most one bit low.
- `seg`  out  7  active-low cathodes `{g,f,e,d,c,b,a}`.
- `dp_n`  out  1  active-low decimal point.
- `frame_start`  out  1  one-cycle pulse when digit 0 begins a new frame.

## Operation
- Reset values:
  - outputs: `anode`=4'b1111, `seg`=7'h7F, `dp_n`=1, `ack`=0, `frame_start`=0.
  - internal: state=BLANK, digit index=0, tick counter=0, shadow=16'h0000, pending=0.
- State machine with two states:
  - BLANK: all anodes high. After `BLANK_TICKS` cycles, go to DRIVE.
  - DRIVE: `anode[idx]`=0, `seg` = decode(shadow nibble `idx`), `dp_n`=~`dp[idx]`. After `TICKS_PER_DIGIT` cycles, go to BLANK and set idx ← (idx+1) mod 4.
- Digit order: 0, 1, 2, 3, then back to 0.
- Wrap: the DRIVE→BLANK exit with idx=3 is the frame boundary. The BLANK→DRIVE entry with idx=0 pulses `frame_start`.
- `load`: captures `value` into a pending register and sets the pending flag.
  - A later `load` before the wrap overwrites the pending value. Only the last value is shown, and only one `ack` is issued.
- At the wrap edge:
  - If pending is set, or `load` is high that cycle, shadow ← (`load` ? `value` : pending value) and pending is cleared.
  - `ack` is high for the single following cycle.
- `enable`=0: `anode`=1111, `seg`=7F, `dp_n`=1. Counters, idx, the handshake and `frame_start` keep running.
- Decode: standard hex. Values 0–F all have a glyph; no input is illegal.

## Timing
- All outputs are registered and change on the same edge as the state transition that causes them.
- First DRIVE (`anode`=1110) begins `BLANK_TICKS` cycles after reset deasserts.
- Frame period is 4·(`TICKS_PER_DIGIT`+`BLANK_TICKS`) cycles.
- Load-to-display latency: from the `load` cycle to the next wrap edge, plus `BLANK_TICKS` cycles. Maximum is one frame plus `BLANK_TICKS`.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock. Any pending load is discarded and no `ack` is issued for it.
- Counter width is $clog2(max(`TICKS_PER_DIGIT`,`BLANK_TICKS`)). The counter resets to 0 on every state change.

## Configuration
- `SEVEN_SEG_LEADING_ZERO_BLANK_EN` defined:
  - Digits above the most significant nonzero nibble of shadow show `seg`=7F while their anode is still driven low.
  - Digit 0 is always shown.
  - `dp` is unaffected.
- Not defined: all four digits are always decoded.

## Structure
- Shared package `seven_seg_pkg` holds:
  - the state enum (BLANK, DRIVE);
  - the 16-entry active-low segment constant table;
  - `SEG_BLANK`=7'h7F and `ANODE_OFF`=4'hF.
- One sub-module, `hex_to_seg`: 4-bit nibble in, 7-bit active-low segments out, purely combinational, using the package table.

## Test plan
All scenarios use `TICKS_PER_DIGIT`=4 and `BLANK_TICKS`=2, giving a 24-cycle frame.
- Reset, then release with `enable`=1 → `anode`=1111/`seg`=7F for 2 cycles, then `anode`=1110 with `seg`=7'h40 ("0") for 4 cycles, then BLANK, then 1101.
- `load` with `value`=16'h1234 mid-frame → display unchanged until the wrap; one `ack` on the cycle after the wrap. Next frame shows `seg`=7'h19 ("4") on 1110, then "3" on 1101, "2" on 1011, "1" on 0111.
- Two loads in one frame (16'h1111, then 16'hABCD) → single `ack`; only ABCD is displayed ("D" on `anode[0]`).
- `enable`=0 for 48 cycles → `anode` stays 1111 throughout, `frame_start` pulses exactly twice, and a load issued meanwhile is still acked.
- Reset asserted during DRIVE with a pending load → outputs return to reset values without a clock edge, no `ack`, and the next frame shows 0000.
- With the macro defined, `value`=16'h0007 → anodes 1..3 driven with `seg`=7F; `anode[0]` shows `seg`=7'h78 ("7").

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment scan controller
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex nibble 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low segment decoder
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// rtl/seven_seg_display_ctrl.sv - 4-digit multiplexed display scanner; SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zeros
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic        ack,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW = $clog2(MAX_TICKS);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    idx, idx_d;
  logic [15:0]   shadow, shadow_d;
  logic [15:0]   pend_value, pend_value_d;
  logic          pending, pending_d;
  logic          wrap;
  logic          ack_d, frame_start_d;
  logic [3:0]    anode_d;
  logic [6:0]    seg_d, digit_seg;
  logic          dp_n_d;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt + CW'(1);
    idx_d         = idx;
    shadow_d      = shadow;
    pend_value_d  = pend_value;
    pending_d     = pending;
    wrap          = 1'b0;
    frame_start_d = 1'b0;
    case (state)
      BLANK: if (cnt == BLANK_LAST) begin
        state_d       = DRIVE;
        cnt_d         = '0;
        frame_start_d = (idx == 2'd0);
      end
      DRIVE: if (cnt == DRIVE_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = idx + 2'd1;
        wrap    = (idx == 2'd3);
      end
      default: state_d = BLANK;
    endcase
    // Updates land only on the frame boundary; a load on that very edge wins
    if (wrap) begin
      if (pending || load) shadow_d = load ? value : pend_value;
      pending_d = 1'b0;
    end else if (load) begin
      pend_value_d = value;
      pending_d    = 1'b1;
    end
    ack_d = wrap && (pending || load);
  end

  hex_to_seg u_hex_to_seg (
    .nibble (shadow_d[{idx_d, 2'b00} +: 4]),
    .seg    (digit_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [1:0] msnz;
  always_comb begin
    msnz = 2'd0;
    if (shadow_d[15:12] != 4'h0)     msnz = 2'd3;
    else if (shadow_d[11:8] != 4'h0) msnz = 2'd2;
    else if (shadow_d[7:4] != 4'h0)  msnz = 2'd1;
  end
`endif

  // Outputs are computed from next-state values so they flip on the transition edge
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    dp_n_d  = 1'b1;
    if (enable && (state_d == DRIVE)) begin
      anode_d = ~(4'b0001 << idx_d);
      seg_d   = digit_seg;
      dp_n_d  = ~dp[idx_d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (idx_d > msnz) seg_d = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      shadow      <= 16'h0000;
      pend_value  <= 16'h0000;
      pending     <= 1'b0;
      ack         <= 1'b0;
      frame_start <= 1'b0;
      anode       <= ANODE_OFF;
      seg         <= SEG_BLANK;
      dp_n        <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      shadow      <= shadow_d;
      pend_value  <= pend_value_d;
      pending     <= pending_d;
      ack         <= ack_d;
      frame_start <= frame_start_d;
      anode       <= anode_d;
      seg         <= seg_d;
      dp_n        <= dp_n_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb/tb_seven_seg_display_ctrl.sv - directed self-checking bench for seven_seg_display_ctrl
module tb_seven_seg_display_ctrl;

  logic        clock = 1'b0;
  logic        reset, enable, load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        ack, dp_n, frame_start;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int pos, total, pass_cnt, fail_cnt;
  int ack_cnt, fs_cnt, lit_cnt, bad_anode;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZERO_HI = 7'h7F;
`else
  localparam logic [6:0] ZERO_HI = 7'h40;
`endif

  seven_seg_display_ctrl #(.TICKS_PER_DIGIT(4), .BLANK_TICKS(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .dp          (dp),
    .load        (load),
    .ack         (ack),
    .anode       (anode),
    .seg         (seg),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge after rising edge p (counted from reset release)
  task automatic run_to(input int p);
    while (pos < p) begin
      @(negedge clock);
      pos++;
      if (ack === 1'b1) ack_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      if (anode !== 4'hF) lit_cnt++;
      if (!(anode inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) bad_anode++;
    end
  endtask

  initial begin
    total = 0; pass_cnt = 0; fail_cnt = 0;
    ack_cnt = 0; fs_cnt = 0; lit_cnt = 0; bad_anode = 0; pos = 0;
    reset = 1'b1; enable = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0;
    repeat (2) @(negedge clock);
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_ack", ack, 1'b0);
    check("rst_fs", frame_start, 1'b0);

    reset = 1'b0; pos = 0;
    run_to(1);  check("blank1_anode", anode, 4'hF); check("blank1_seg", seg, 7'h7F);
    run_to(2);  check("d0_anode", anode, 4'hE); check("d0_seg", seg, 7'h40);
    check("d0_fs", frame_start, 1'b1); check("d0_dp_n", dp_n, 1'b1);
    run_to(3);  check("d0_fs_pulse", frame_start, 1'b0);
    run_to(5);  check("d0_last", anode, 4'hE);
    run_to(6);  check("gap_anode", anode, 4'hF);
    run_to(8);  check("d1_anode", anode, 4'hD); check("d1_seg", seg, ZERO_HI);

    value = 16'h1234; load = 1'b1;
    run_to(9);  load = 1'b0; value = 16'h0; ack_cnt = 0;
    check("ld_hold_seg", seg, ZERO_HI);
    run_to(20); check("ld_d3_anode", anode, 4'h7); check("ld_d3_seg", seg, ZERO_HI);
    run_to(23); check("ld_no_early_ack", ack_cnt, 0);
    run_to(24); check("ld_ack", ack, 1'b1);
    run_to(25); check("ld_ack_pulse", ack, 1'b0);
    dp = 4'b0010;
    run_to(26); check("f1_d0_anode", anode, 4'hE); check("f1_d0_seg", seg, 7'h19);
    check("f1_fs", frame_start, 1'b1); check("f1_d0_dp_n", dp_n, 1'b1);
    run_to(32); check("f1_d1_anode", anode, 4'hD); check("f1_d1_seg", seg, 7'h30);
    check("f1_d1_dp_n", dp_n, 1'b0);
    run_to(38); check("f1_d2_anode", anode, 4'hB); check("f1_d2_seg", seg, 7'h24);
    run_to(44); check("f1_d3_anode", anode, 4'h7); check("f1_d3_seg", seg, 7'h79);

    ack_cnt = 0; dp = 4'h0;
    run_to(50); value = 16'h1111; load = 1'b1;
    run_to(51); load = 1'b0;
    run_to(60); value = 16'hABCD; load = 1'b1;
    run_to(61); load = 1'b0; value = 16'h0;
    run_to(72); check("dbl_ack", ack, 1'b1);
    run_to(74); check("dbl_d0_seg", seg, 7'h21);
    run_to(80); check("dbl_d1_seg", seg, 7'h46); check("dbl_ack_count", ack_cnt, 1);
    run_to(86); check("dbl_d2_seg", seg, 7'h03);
    run_to(92); check("dbl_d3_seg", seg, 7'h08);

    run_to(96); enable = 1'b0; ack_cnt = 0; fs_cnt = 0; lit_cnt = 0;
    run_to(100); value = 16'h00C5; load = 1'b1;
    run_to(101); load = 1'b0; value = 16'h0;
    run_to(144);
    check("dis_dark", lit_cnt, 0);
    check("dis_fs_count", fs_cnt, 2);
    check("dis_ack_count", ack_cnt, 1);
    check("dis_seg", seg, 7'h7F);
    enable = 1'b1;
    run_to(146); check("en_d0_anode", anode, 4'hE); check("en_d0_seg", seg, 7'h12);

    run_to(153); value = 16'h9999; load = 1'b1;
    run_to(154); load = 1'b0; value = 16'h0;
    check("pre_rst_anode", anode, 4'hD);
    #2 reset = 1'b1;
    #1;
    check("async_anode", anode, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp_n", dp_n, 1'b1);
    repeat (2) @(negedge clock);
    check("rst_hold_ack", ack, 1'b0);
    reset = 1'b0; pos = 0; ack_cnt = 0;
    run_to(2);  check("rr_d0_anode", anode, 4'hE); check("rr_d0_seg", seg, 7'h40);
    run_to(8);  check("rr_d1_seg", seg, ZERO_HI);
    run_to(24); check("rr_no_ack", ack_cnt, 0);
    run_to(26); check("rr_f1_d0_seg", seg, 7'h40);

    run_to(30); value = 16'h0007; load = 1'b1;
    run_to(31); load = 1'b0; value = 16'h0;
    run_to(48); check("lz_ack", ack, 1'b1);
    run_to(50); check("lz_d0_anode", anode, 4'hE); check("lz_d0_seg", seg, 7'h78);
    run_to(56); check("lz_d1_anode", anode, 4'hD); check("lz_d1_seg", seg, ZERO_HI);
    run_to(62); check("lz_d2_anode", anode, 4'hB); check("lz_d2_seg", seg, ZERO_HI);
    run_to(68); check("lz_d3_anode", anode, 4'h7); check("lz_d3_seg", seg, ZERO_HI);

    check("anode_onehot", bad_anode, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
